// File: rtl/decode_sequencer.sv
// Registered instruction decoder with a two-phase branch/JAL sequencer and a fetch valid/ready port.
// Define DECSEQ_SIGNED_OFFSET_EN to sign-extend immediates; default build zero-extends them.
module decode_sequencer #(
    parameter int DATA_W = 16,
    parameter int PC_REG = 7,
    parameter int PC_ADJ = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    input  logic [15:0]       inst,
    output logic              inst_ready,
    input  logic [1:0]        flags,
    output logic [2:0]        alu_op,
    output logic [2:0]        ra_add,
    output logic [2:0]        rb_add,
    output logic [2:0]        write_add,
    output logic              w_en,
    output logic              load_store,
    output logic              pc_inc,
    output logic [DATA_W-1:0] immediate,
    output logic              busy,
    output logic              illegal,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, BRANCH = 2'd2} state_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_NDU = 4'h2;
    localparam logic [3:0] OP_LW  = 4'h4;
    localparam logic [3:0] OP_SW  = 4'h5;
    localparam logic [3:0] OP_JAL = 4'h8;
    localparam logic [3:0] OP_BEQ = 4'hC;
    localparam logic [2:0]        PC_IDX = 3'(PC_REG);
    localparam logic [DATA_W-1:0] ADJ    = DATA_W'(PC_ADJ);

    state_t            state;
    logic [15:0]       ir;
    logic [3:0]        opcode;
    logic              take_branch;
    logic              accept;
    logic [DATA_W-1:0] ext6;
    logic [DATA_W-1:0] ext9;
    logic              unused_flags;

    assign opcode       = ir[15:12];
    assign unused_flags = flags[1];

`ifdef DECSEQ_SIGNED_OFFSET_EN
    assign ext6 = {{(DATA_W-6){ir[5]}}, ir[5:0]};
    assign ext9 = {{(DATA_W-9){ir[8]}}, ir[8:0]};
`else
    assign ext6 = {{(DATA_W-6){1'b0}}, ir[5:0]};
    assign ext9 = {{(DATA_W-9){1'b0}}, ir[8:0]};
`endif

    // Handshake: an instruction is consumed on a rising edge where inst_valid and
    // inst_ready are both high; inst must be held stable while inst_ready is low.
    assign take_branch = (state == EXEC) &&
                         (((opcode == OP_BEQ) && flags[0]) || (opcode == OP_JAL));
    assign inst_ready  = rst_n && !take_branch;
    assign accept      = inst_valid && inst_ready;
    assign busy        = (state != FETCH);
    assign state_dbg   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            ir    <= 16'h0000;
        end else if (take_branch) begin
            state <= BRANCH;
        end else if (accept) begin
            state <= EXEC;
            ir    <= inst;
        end else begin
            state <= FETCH;
        end
    end

    always_comb begin
        alu_op     = 3'b000;
        ra_add     = 3'd0;
        rb_add     = 3'd0;
        write_add  = 3'd0;
        w_en       = 1'b0;
        load_store = 1'b0;
        pc_inc     = 1'b0;
        immediate  = '0;
        illegal    = 1'b0;
        if (state == EXEC) begin
            case (opcode)
                OP_ADD, OP_NDU: begin
                    alu_op    = (opcode == OP_NDU) ? 3'b001 : 3'b000;
                    ra_add    = ir[11:9];
                    rb_add    = ir[8:6];
                    write_add = ir[5:3];
                    w_en      = 1'b1;
                    pc_inc    = 1'b1;
                end
                OP_LW: begin
                    alu_op     = 3'b111;
                    rb_add     = ir[8:6];
                    write_add  = ir[11:9];
                    immediate  = ext6;
                    load_store = 1'b1;
                    w_en       = 1'b1;
                    pc_inc     = 1'b1;
                end
                OP_SW: begin
                    alu_op    = 3'b111;
                    ra_add    = ir[11:9];
                    rb_add    = ir[8:6];
                    immediate = ext6;
                    pc_inc    = 1'b1;
                end
                OP_BEQ: begin
                    alu_op = 3'b010;
                    ra_add = ir[11:9];
                    rb_add = ir[8:6];
                    pc_inc = !flags[0];
                end
                OP_JAL: begin
                    alu_op    = 3'b011;
                    rb_add    = PC_IDX;
                    write_add = ir[11:9];
                    immediate = ADJ;
                    w_en      = 1'b1;
                end
                default: begin
                    illegal = 1'b1;
                    pc_inc  = 1'b1;
                end
            endcase
        end else if (state == BRANCH) begin
            // Second phase writes the PC: offset is compensated for the pre-increment.
            alu_op    = 3'b011;
            rb_add    = PC_IDX;
            write_add = PC_IDX;
            w_en      = 1'b1;
            pc_inc    = 1'b1;
            immediate = ((opcode == OP_BEQ) ? ext6 : ext9) - ADJ;
        end
    end

endmodule

// File: tb/tb_decode_sequencer.sv
// Self-checking bench for decode_sequencer: per-cycle expected output vectors in a scoreboard queue.
module tb_decode_sequencer;

    logic        clk;
    logic        rst_n;
    logic        inst_valid;
    logic [15:0] inst;
    logic        inst_ready;
    logic [1:0]  flags;
    logic [2:0]  alu_op, ra_add, rb_add, write_add;
    logic        w_en, load_store, pc_inc, busy, illegal;
    logic [15:0] immediate;
    logic [1:0]  state_dbg;

    logic [33:0] obs;
    logic [33:0] exp_q[$];
    logic [1:0]  fl_q[$];
    logic [15:0] prog[$];
    logic [1:0]  pf[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    decode_sequencer dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst),
        .inst_ready(inst_ready), .flags(flags), .alu_op(alu_op), .ra_add(ra_add),
        .rb_add(rb_add), .write_add(write_add), .w_en(w_en), .load_store(load_store),
        .pc_inc(pc_inc), .immediate(immediate), .busy(busy), .illegal(illegal),
        .state_dbg(state_dbg)
    );

    assign obs = {alu_op, ra_add, rb_add, write_add, w_en, load_store, pc_inc,
                  inst_ready, busy, illegal, immediate};

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] mk(input logic [2:0] alu, input logic [2:0] ra,
                                       input logic [2:0] rb, input logic [2:0] wa,
                                       input logic we, input logic ls, input logic pc,
                                       input logic rdy, input logic bsy, input logic ill,
                                       input logic [15:0] imm);
        return {alu, ra, rb, wa, we, ls, pc, rdy, bsy, ill, imm};
    endfunction

    function automatic logic [15:0] ext(input logic [15:0] v, input int bits);
        logic [15:0] m;
        m = 16'hFFFF << bits;
`ifdef DECSEQ_SIGNED_OFFSET_EN
        if (v[bits-1]) return v | m;
`endif
        return v & ~m;
    endfunction

    function automatic logic taken(input logic [15:0] i, input logic [1:0] f);
        return (i[15:12] == 4'h8) || (i[15:12] == 4'hC && f[0]);
    endfunction

    function automatic logic [33:0] exp_exec(input logic [15:0] i, input logic [1:0] f);
        logic [2:0] a, b, c;
        a = i[11:9]; b = i[8:6]; c = i[5:3];
        case (i[15:12])
            4'h0: return mk(3'd0, a, b, c, 1, 0, 1, 1, 1, 0, 16'h0);
            4'h2: return mk(3'd1, a, b, c, 1, 0, 1, 1, 1, 0, 16'h0);
            4'h4: return mk(3'd7, 0, b, a, 1, 1, 1, 1, 1, 0, ext(i, 6));
            4'h5: return mk(3'd7, a, b, 0, 0, 0, 1, 1, 1, 0, ext(i, 6));
            4'hC: return mk(3'd2, a, b, 0, 0, 0, !f[0], !f[0], 1, 0, 16'h0);
            4'h8: return mk(3'd3, 0, 3'd7, a, 1, 0, 0, 0, 1, 0, 16'd2);
            default: return mk(3'd0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 16'h0);
        endcase
    endfunction

    function automatic logic [33:0] exp_branch(input logic [15:0] i);
        logic [15:0] off;
        off = (i[15:12] == 4'hC) ? ext(i, 6) - 16'd2 : ext(i, 9) - 16'd2;
        return mk(3'd3, 0, 3'd7, 3'd7, 1, 0, 1, 1, 1, 0, off);
    endfunction

    // driver: presents prog back-to-back, scoreboard holds one expected vector per cycle
    task automatic run_prog();
        int          idx = 0;
        int          cyc = 0;
        logic        acc;
        logic [33:0] e;
        exp_q = {};
        fl_q  = {};
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0));
        fl_q.push_back(2'($urandom_range(0, 3)));
        foreach (prog[k]) begin
            exp_q.push_back(exp_exec(prog[k], pf[k]));
            fl_q.push_back(pf[k]);
            if (taken(prog[k], pf[k])) begin
                exp_q.push_back(exp_branch(prog[k]));
                fl_q.push_back(2'($urandom_range(0, 3)));
            end
        end
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0));
            fl_q.push_back(2'($urandom_range(0, 3)));
        end
        @(negedge clk);
        inst_valid = 1'b1;
        inst       = prog[0];
        while (exp_q.size() > 0 && cyc < 400) begin
            flags = fl_q.pop_front();
            e     = exp_q.pop_front();
            #1;
            check($sformatf("cycle%0d_inst%0d", cyc, idx), 64'(obs), 64'(e));
            acc = inst_valid & inst_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < prog.size()) inst = prog[idx];
                else begin
                    inst_valid = 1'b0;
                    inst       = 16'($urandom);
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("prog_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst       = 16'h0;
        flags      = 2'b00;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'(obs), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0)));
        rst_n = 1'b1;
        #1;
        check("reset_release", 64'(obs), 64'(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0)));

        // directed sequence, then random instructions with random flags
        prog = '{16'h0298, 16'h4A85, 16'hC2BE, 16'hC2BE, 16'h8C05, 16'hF000,
                 16'h5A7F, 16'h2B58, 16'h45E3, 16'h8FFF};
        pf   = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00};
        for (int k = 0; k < 30; k++) begin
            prog.push_back(16'($urandom));
            pf.push_back(2'($urandom_range(0, 3)));
        end
        run_prog();

        // reset asserted while the sequencer is in BRANCH
        @(negedge clk);
        inst_valid = 1'b1;
        inst       = 16'h8C05;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_reset_branch", 64'(obs), 64'(exp_branch(16'h8C05)));
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_branch", 64'(obs), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0)));
        check("reset_state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_ready", 64'(obs), 64'(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0)));

        prog = '{16'h0298, 16'h0F000, 16'h2B58};
        pf   = '{2'b00, 2'b00, 2'b00};
        run_prog();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
